// File: rtl/nic_router_port_if.sv
// Router local-port link bundle: the NIC-facing net_* wires plus crossbar-side ingress/egress and status.
// slave is the router port; master is whatever drives it (NIC + crossbar model).
interface nic_router_port_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  logic              net_polarity;
  logic              net_so;
  logic [0:DATA_W-1] net_do;
  logic              net_ro;
  logic              net_si;
  logic [0:DATA_W-1] net_di;
  logic              net_ri;
  logic              rtr_ing_valid;
  logic [0:DATA_W-1] rtr_ing_data;
  logic              rtr_ing_gnt;
  logic              rtr_eg_valid;
  logic [0:DATA_W-1] rtr_eg_data;
  logic              rtr_eg_ready;
  logic              vc_err;
  logic [CNT_W-1:0]  in_cnt;
  logic [CNT_W-1:0]  out_cnt;

  modport slave (
    output net_polarity,
    input  net_so, net_do,
    output net_ro,
    output net_si, net_di,
    input  net_ri,
    output rtr_ing_valid, rtr_ing_data,
    input  rtr_ing_gnt,
    input  rtr_eg_valid, rtr_eg_data,
    output rtr_eg_ready,
    output vc_err, in_cnt, out_cnt
  );

  modport master (
    input  net_polarity,
    output net_so, net_do,
    input  net_ro,
    input  net_si, net_di,
    output net_ri,
    input  rtr_ing_valid, rtr_ing_data,
    output rtr_ing_gnt,
    output rtr_eg_valid, rtr_eg_data,
    input  rtr_eg_ready,
    input  vc_err, in_cnt, out_cnt
  );
endinterface

// File: rtl/nic_router_port.sv
// Router-side local port for nic_mesh: one-entry buffer per VC in each direction, phase owner.
// PH_EVEN | VC0 uses the NIC link, VC1 talks to the crossbar ; PH_ODD | roles swapped
module nic_router_port #(
  parameter int DATA_W = 64,
  parameter int VC_BIT = 0,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              reset,
  nic_router_port_if.slave bus
);

  typedef enum logic {PH_EVEN = 1'b0, PH_ODD = 1'b1} phase_t;

  phase_t r_phase;
  phase_t w_phase_nxt;

  logic              w_pol;
  logic              w_npol;
  logic [1:0]        r_ib_full;
  logic [0:DATA_W-1] r_ib [2];
  logic [1:0]        r_eb_full;
  logic [0:DATA_W-1] r_eb [2];
  logic [CNT_W-1:0]  r_in_cnt;
  logic [CNT_W-1:0]  r_out_cnt;
  logic              r_vc_err;

  logic w_acc;
  logic w_push;
  logic w_bad;
  logic w_ing_pop;
  logic w_eg_vc;
  logic w_eg_ready;
  logic w_eg_wr;
  logic w_si;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_phase <= PH_EVEN;
    else       r_phase <= w_phase_nxt;
  end

  always_comb begin
    w_phase_nxt = PH_EVEN;
    case (r_phase)
      PH_EVEN: w_phase_nxt = PH_ODD;
      PH_ODD:  w_phase_nxt = PH_EVEN;
      default: w_phase_nxt = PH_EVEN;
    endcase
  end

  assign w_pol  = (r_phase == PH_ODD);
  assign w_npol = ~w_pol;

  assign w_acc     = bus.net_so & ~r_ib_full[w_pol];
  assign w_push    = w_acc & (bus.net_do[VC_BIT] == w_pol);
  assign w_bad     = w_acc & (bus.net_do[VC_BIT] != w_pol);
  assign w_ing_pop = r_ib_full[w_npol] & bus.rtr_ing_gnt;

  // Egress writes only the internal-phase VC while the external one drains, so they never collide.
  assign w_eg_vc    = bus.rtr_eg_data[VC_BIT];
  assign w_eg_ready = (w_eg_vc != w_pol) & ~r_eb_full[w_eg_vc];
  assign w_eg_wr    = bus.rtr_eg_valid & w_eg_ready;
  assign w_si       = r_eb_full[w_pol] & bus.net_ri;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ib_full <= 2'b00;
      r_eb_full <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        r_ib[i] <= '0;
        r_eb[i] <= '0;
      end
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_vc_err  <= 1'b0;
    end else begin
      r_vc_err <= w_bad;
      if (w_push) begin
        r_ib[w_pol]      <= bus.net_do;
        r_ib_full[w_pol] <= 1'b1;
        r_in_cnt         <= r_in_cnt + CNT_W'(1);
      end
      if (w_ing_pop) r_ib_full[w_npol] <= 1'b0;
      if (w_eg_wr) begin
        r_eb[w_eg_vc]      <= bus.rtr_eg_data;
        r_eb_full[w_eg_vc] <= 1'b1;
      end
      if (w_si) begin
        r_eb_full[w_pol] <= 1'b0;
        r_out_cnt        <= r_out_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.net_polarity  = w_pol;
  assign bus.net_ro        = ~r_ib_full[w_pol];
  assign bus.rtr_ing_valid = r_ib_full[w_npol];
  assign bus.rtr_ing_data  = r_ib_full[w_npol] ? r_ib[w_npol] : '0;
  assign bus.rtr_eg_ready  = w_eg_ready;
  assign bus.net_si        = w_si;
  assign bus.net_di        = w_si ? r_eb[w_pol] : '0;
  assign bus.vc_err        = r_vc_err;
  assign bus.in_cnt        = r_in_cnt;
  assign bus.out_cnt       = r_out_cnt;

endmodule

// File: tb/tb_nic_router_port.sv
// Bench for nic_router_port: vector table, directed corner sequences, random run against a VC-buffer model.
module tb_nic_router_port;
  localparam int DW = 64;
  localparam logic [0:63] PKT_V1 = 64'h8000_0000_0000_0084;
  localparam logic [0:63] PKT_WR = 64'h8000_0000_0000_000B;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  nic_router_port_if #(.DATA_W(DW), .CNT_W(16)) bus ();
  nic_router_port #(.DATA_W(DW), .VC_BIT(0), .CNT_W(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic so; logic [0:63] d; logic ri; logic gnt; logic egv; logic [0:63] egd;
    logic e_pol; logic e_ro; logic e_iv; logic [0:63] e_idata; logic e_er;
    logic e_si; logic [0:63] e_di; logic e_err; logic [15:0] e_inc; logic [15:0] e_outc;
  } vec_t;
  vec_t tbl [5];

  // model state: one optional packet per VC per direction, phase as a bit
  bit          m_pol;
  bit          m_ibv [2];
  logic [0:63] m_ibd [2];
  bit          m_ebv [2];
  logic [0:63] m_ebd [2];
  int          m_inc, m_outc;
  bit          m_err;

  logic        r_so, r_ri, r_gnt, r_egv;
  logic [0:63] r_d, r_egd;
  int          p, q, vc;
  logic        x_er, x_si;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic so, input logic [0:63] d, input logic ri, input logic gnt,
                       input logic egv, input logic [0:63] egd);
    bus.net_so = so; bus.net_do = d; bus.net_ri = ri;
    bus.rtr_ing_gnt = gnt; bus.rtr_eg_valid = egv; bus.rtr_eg_data = egd;
  endtask

  task automatic next_cycle;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(0, '0, 0, 0, 0, '0);
    next_cycle(); next_cycle();
    reset = 1'b0;
  endtask

  initial begin
    drive(0, '0, 0, 0, 0, '0);
    tbl[0] = '{1'b1, 64'd32, 1'b0, 1'b0, 1'b1, PKT_V1,
               1'b0, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b0, 16'd0, 16'd0};
    tbl[1] = '{1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 64'd0,
               1'b1, 1'b1, 1'b1, 64'd32, 1'b1, 1'b1, PKT_V1, 1'b0, 16'd1, 16'd0};
    tbl[2] = '{1'b1, PKT_WR, 1'b0, 1'b0, 1'b0, 64'd0,
               1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 16'd1, 16'd1};
    tbl[3] = '{1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0,
               1'b1, 1'b1, 1'b0, 64'd0, 1'b1, 1'b0, 64'd0, 1'b1, 16'd1, 16'd1};
    tbl[4] = '{1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0,
               1'b0, 1'b1, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0, 16'd1, 16'd1};

    // T2/T3/T6 as a cycle-by-cycle vector table
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i].so, tbl[i].d, tbl[i].ri, tbl[i].gnt, tbl[i].egv, tbl[i].egd);
      @(negedge clk);
      chk($sformatf("v%0d_pol", i), 64'(bus.net_polarity), 64'(tbl[i].e_pol));
      chk($sformatf("v%0d_ro", i), 64'(bus.net_ro), 64'(tbl[i].e_ro));
      chk($sformatf("v%0d_ing_valid", i), 64'(bus.rtr_ing_valid), 64'(tbl[i].e_iv));
      chk($sformatf("v%0d_ing_data", i), bus.rtr_ing_data, tbl[i].e_idata);
      chk($sformatf("v%0d_eg_ready", i), 64'(bus.rtr_eg_ready), 64'(tbl[i].e_er));
      chk($sformatf("v%0d_si", i), 64'(bus.net_si), 64'(tbl[i].e_si));
      chk($sformatf("v%0d_di", i), bus.net_di, tbl[i].e_di);
      chk($sformatf("v%0d_vc_err", i), 64'(bus.vc_err), 64'(tbl[i].e_err));
      chk($sformatf("v%0d_in_cnt", i), 64'(bus.in_cnt), 64'(tbl[i].e_inc));
      chk($sformatf("v%0d_out_cnt", i), 64'(bus.out_cnt), 64'(tbl[i].e_outc));
      next_cycle();
    end

    // T4 backpressure: VC1 packet held through two odd phases with net_ri=0
    do_reset();
    drive(0, '0, 0, 0, 1, PKT_V1); next_cycle();
    drive(0, '0, 0, 0, 0, PKT_V1); @(negedge clk);
    chk("t4_si_hold1", 64'(bus.net_si), 64'd0); next_cycle();
    @(negedge clk);
    chk("t4_ready_full", 64'(bus.rtr_eg_ready), 64'd0); next_cycle();
    @(negedge clk);
    chk("t4_si_hold2", 64'(bus.net_si), 64'd0); next_cycle();
    next_cycle();
    drive(0, '0, 1, 0, 0, PKT_V1); @(negedge clk);
    chk("t4_si_release", 64'(bus.net_si), 64'd1);
    chk("t4_di", bus.net_di, PKT_V1); next_cycle();
    drive(0, '0, 0, 0, 0, PKT_V1); @(negedge clk);
    chk("t4_out_cnt", 64'(bus.out_cnt), 64'd1);
    chk("t4_ready_free", 64'(bus.rtr_eg_ready), 64'd1); next_cycle();
    drive(0, '0, 1, 0, 0, '0); @(negedge clk);
    chk("t4_once_si", 64'(bus.net_si), 64'd0);
    chk("t4_once_cnt", 64'(bus.out_cnt), 64'd1); next_cycle();

    // T5 full: ib[0] never granted, later even-phase sends are refused
    do_reset();
    drive(1, 64'd32, 0, 0, 0, '0); next_cycle();
    drive(0, '0, 0, 0, 0, '0); @(negedge clk);
    chk("t5_ing_data", bus.rtr_ing_data, 64'd32); next_cycle();
    for (int k = 0; k < 2; k++) begin
      drive(1, 64'd5, 0, 0, 0, '0); @(negedge clk);
      chk($sformatf("t5_ro_%0d", k), 64'(bus.net_ro), 64'd0); next_cycle();
      drive(0, '0, 0, 0, 0, '0); @(negedge clk);
      chk($sformatf("t5_in_cnt_%0d", k), 64'(bus.in_cnt), 64'd1);
      chk($sformatf("t5_hold_data_%0d", k), bus.rtr_ing_data, 64'd32);
      chk($sformatf("t5_no_err_%0d", k), 64'(bus.vc_err), 64'd0);
      next_cycle();
    end

    // T1 reset in the middle of an egress delivery cycle
    do_reset();
    drive(1, 64'd32, 0, 0, 1, PKT_V1); next_cycle();
    drive(0, '0, 1, 0, 0, '0); @(negedge clk);
    chk("t1_pre_si", 64'(bus.net_si), 64'd1);
    #2 reset = 1'b1; #1;
    chk("t1_pol", 64'(bus.net_polarity), 64'd0);
    chk("t1_ro", 64'(bus.net_ro), 64'd1);
    chk("t1_si", 64'(bus.net_si), 64'd0);
    chk("t1_ing_valid", 64'(bus.rtr_ing_valid), 64'd0);
    chk("t1_in_cnt", 64'(bus.in_cnt), 64'd0);
    chk("t1_out_cnt", 64'(bus.out_cnt), 64'd0);

    // random traffic against the buffer model
    do_reset();
    m_pol = 0; m_ibv = '{0, 0}; m_ebv = '{0, 0}; m_inc = 0; m_outc = 0; m_err = 0;
    m_ibd = '{64'd0, 64'd0}; m_ebd = '{64'd0, 64'd0};
    for (int n = 0; n < 1500; n++) begin
      r_so = 1'($urandom_range(0, 1)); r_ri = 1'($urandom_range(0, 1));
      r_gnt = 1'($urandom_range(0, 1)); r_egv = 1'($urandom_range(0, 1));
      r_d = {$urandom, $urandom}; r_egd = {$urandom, $urandom};
      drive(r_so, r_d, r_ri, r_gnt, r_egv, r_egd);
      @(negedge clk);
      p = int'(m_pol); q = 1 - p; vc = int'(r_egd[0]);
      x_er = (vc != p) && !m_ebv[vc];
      x_si = m_ebv[p] && r_ri;
      chk("r_pol", 64'(bus.net_polarity), 64'(m_pol));
      chk("r_ro", 64'(bus.net_ro), 64'(!m_ibv[p]));
      chk("r_ing_valid", 64'(bus.rtr_ing_valid), 64'(m_ibv[q]));
      chk("r_ing_data", bus.rtr_ing_data, m_ibv[q] ? m_ibd[q] : 64'd0);
      chk("r_eg_ready", 64'(bus.rtr_eg_ready), 64'(x_er));
      chk("r_si", 64'(bus.net_si), 64'(x_si));
      chk("r_di", bus.net_di, x_si ? m_ebd[p] : 64'd0);
      chk("r_vc_err", 64'(bus.vc_err), 64'(m_err));
      chk("r_in_cnt", 64'(bus.in_cnt), 64'(m_inc % 65536));
      chk("r_out_cnt", 64'(bus.out_cnt), 64'(m_outc % 65536));
      m_err = 0;
      if (r_so && !m_ibv[p]) begin
        if (int'(r_d[0]) == p) begin
          m_ibv[p] = 1; m_ibd[p] = r_d; m_inc++;
        end else m_err = 1;
      end
      if (m_ibv[q] && r_gnt) m_ibv[q] = 0;
      if (r_egv && x_er) begin
        m_ebv[vc] = 1; m_ebd[vc] = r_egd;
      end
      if (x_si) begin
        m_ebv[p] = 0; m_outc++;
      end
      m_pol = !m_pol;
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
